issue_ctrl: RTL
===============

# issue_ctrl

Pipeline issue controller sitting beside the decode stage. It decides every cycle whether the instruction in ID issues into EX, and whether IF/ID stall, flush or receive a bubble. It tracks in-flight register writes in an 8-entry scoreboard, honours data-memory stalls and EX-stage redirects, and drains the pipeline on a halt (dump) instruction. It replaces ad-hoc stall logic and counts hazard stall cycles for performance checks.

## Interface
- WB_LAT, 3, cycles from issue until the write reaches WB; legal range 2..3 (2-bit counters)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  3  first source register (instr[10:8])
- id_rs_use  in  1  first source is read
- id_rt  in  3  second source register (instr[7:5])
- id_rt_use  in  1  second source is read
- id_wr_en  in  1  ID instruction writes the register file
- id_wr_reg  in  3  destination register of ID instruction
- id_halt  in  1  ID instruction is halt/dump
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle
- mem_stall  in  1  data memory busy; whole pipe freezes
- issue  out  1  ID instruction advances to EX at next edge
- stall_if  out  1  hold PC and IF/ID register
- stall_id  out  1  hold ID contents
- bubble_ex  out  1  load a NOP into ID/EX
- flush_id  out  1  replace IF/ID contents with NOP
- halted  out  1  pipeline drained after halt
- stall_cycles  out  16  saturating count of RAW-hazard stall cycles

## Operation
- State: FSM {RUN, DRAIN, HALTED}; cnt[0..7], 2 bits each; stall_cycles.
- hazard = id_valid & ((id_rs_use & cnt[id_rs] > 1) | (id_rt_use & cnt[id_rt] > 1)). Threshold >1 because register-file bypass makes a WB write visible in ID the same cycle.
- Outputs are combinational from state and inputs. Priority, highest first:
  - mem_stall: stall_if=1, stall_id=1, bubble_ex=0, flush_id=0, issue=0.
  - DRAIN or HALTED: stall_if=1, stall_id=1, bubble_ex=1, issue=0; ex_redirect is ignored.
  - RUN & ex_redirect: flush_id=1, bubble_ex=1, stall_if=0, stall_id=0, issue=0.
  - RUN & hazard: stall_if=1, stall_id=1, bubble_ex=1, issue=0.
  - RUN otherwise: issue=id_valid, bubble_ex=~id_valid, all others 0.
- halted=1 only in HALTED.
- Scoreboard update at the edge, only when ~mem_stall. For each r:
  - if issue & id_wr_en & id_wr_reg==r: cnt[r] <= WB_LAT;
  - else if cnt[r]!=0: cnt[r] <= cnt[r]-1.
- ex_redirect never clears counters: older producers still complete.
- An instruction that reads and writes the same register checks hazard against the old cnt.
- FSM transitions:
  - RUN→DRAIN at the edge where issue & id_halt.
  - DRAIN→HALTED at the first edge with all cnt==0 and ~mem_stall.
  - HALTED is held until rst.
- stall_cycles increments at edges where the RUN & hazard row is selected (not under mem_stall, not under redirect). It saturates at 0xFFFF.

## Timing
- rst asserted (any time, asynchronous): state=RUN, all cnt=0, stall_cycles=0.
  - With id_valid=0 this gives issue=0, bubble_ex=1, and all other outputs 0.
  - Reset mid-DRAIN returns to RUN immediately.
- Producer issued at edge e0 with WB_LAT=3 (cnt after e0 = 3, after e1 = 2, after e2 = 1):
  - A dependent instruction in ID at the cycle after e0 or e1 stalls.
  - It issues in the cycle after e2. Back-to-back dependency costs 2 stall cycles; distance 2 costs 1; distance 3 costs 0.
- mem_stall freezes cnt, FSM and stall_cycles. Stall durations extend by exactly the mem_stall cycles.
- Halt issued at edge e0 with no pending writes: cnt all 0 in the DRAIN cycle, so halted=1 after e1.

## Test plan
- Reset: pulse rst asynchronously mid-DRAIN with cnt[5]=2 -> immediately state RUN, all cnt 0, halted=0, stall_cycles=0, issue=0, bubble_ex=1.
- Back-to-back RAW: issue write r3, next instr reads r3 (id_rs_use=1) -> stall_if=stall_id=bubble_ex=1 for 2 cycles, issue=1 on 3rd cycle, stall_cycles=2. Repeat at distance 2 -> 1 stall; at distance 3 -> 0 stalls.
- mem_stall during hazard: back-to-back r3 dependency, mem_stall=1 for 3 cycles starting on the first stall cycle -> issue delayed by 5 cycles total, stall_cycles=2, bubble_ex=0 while mem_stall.
- Redirect vs hazard: ex_redirect=1 in a cycle where hazard=1 -> flush_id=1, bubble_ex=1, stall_if=0, issue=0, stall_cycles unchanged, cnt continues decrementing.
- Halt drain: write r5 issues, halt issues next cycle -> DRAIN with stall_if=1, bubble_ex=1; halted=1 after the third edge following the halt's issue edge; stays 1 with ex_redirect toggling.
- Saturation: force 65 540 hazard stall cycles -> stall_cycles holds 0xFFFF, no wrap.

Source files
------------

// File: rtl/issue_ctrl.sv
// Issue controller beside the decode stage: RAW scoreboard, stall/flush/bubble
// steering, halt drain and a saturating hazard stall counter.
module issue_ctrl #(
   parameter int WB_LAT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [2:0]  id_rs,
   input  logic        id_rs_use,
   input  logic [2:0]  id_rt,
   input  logic        id_rt_use,
   input  logic        id_wr_en,
   input  logic [2:0]  id_wr_reg,
   input  logic        id_halt,
   input  logic        ex_redirect,
   input  logic        mem_stall,
   output logic        issue,
   output logic        stall_if,
   output logic        stall_id,
   output logic        bubble_ex,
   output logic        flush_id,
   output logic        halted,
   output logic [15:0] stall_cycles
);

   localparam logic [1:0] WB_LAT_C = 2'(WB_LAT);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t           state, state_nxt;
   logic [7:0][1:0]  cnt;
   logic             hazard;
   logic             all_clear;
   logic             hazard_stall;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Threshold >1: a write reaching WB is bypassed through the register file.
   assign hazard = id_valid & ((id_rs_use & (cnt[id_rs] > 2'd1)) |
                               (id_rt_use & (cnt[id_rt] > 2'd1)));
   assign all_clear    = (cnt == '0);
   assign hazard_stall = (state == RUN) & ~mem_stall & ~ex_redirect & hazard;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= RUN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (issue & id_halt) state_nxt = DRAIN;
         DRAIN:   if (all_clear & ~mem_stall) state_nxt = HALTED;
         HALTED:  state_nxt = HALTED;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      issue     = 1'b0;
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      bubble_ex = 1'b0;
      flush_id  = 1'b0;
      if (mem_stall) begin
         stall_if = 1'b1;
         stall_id = 1'b1;
      end else if (state != RUN) begin
         stall_if  = 1'b1;
         stall_id  = 1'b1;
         bubble_ex = 1'b1;
      end else if (ex_redirect) begin
         flush_id  = 1'b1;
         bubble_ex = 1'b1;
      end else if (hazard) begin
         stall_if  = 1'b1;
         stall_id  = 1'b1;
         bubble_ex = 1'b1;
      end else begin
         issue     = id_valid;
         bubble_ex = ~id_valid;
      end
   end

   assign halted = (state == HALTED);

   // Counters keep draining across redirects: older producers still complete.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!mem_stall) begin
         for (int r = 0; r < 8; r++) begin
            if (issue && id_wr_en && (id_wr_reg == 3'(r)))
               cnt[r] <= WB_LAT_C;
            else if (cnt[r] != 2'd0)
               cnt[r] <= cnt[r] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cycles <= '0;
      else if (hazard_stall)
         stall_cycles <= sat_inc(stall_cycles);
   end

endmodule
